swd_xfer_sequencer: RTL and testbench
=====================================

# swd_xfer_sequencer

MCU-facing transaction sequencer that sits directly upstream of `swd_frontend_top`. It accepts one SWD transfer command (APnDP, RnW, A[3:2], write data) and serialises it into the fixed 48-bit frame on `mosi`. It frames each transfer with the front end's `rst_n`/`rnw` controls and samples `miso` to recover ACK and read data. It retries WAIT responses automatically and returns one response per command over a valid/ready handshake.

## Interface
- `IDLE_CYCLES`, default 4: cycles `fe_rst_n` is held low before every frame, including retries; legal range 1..15.
- `RETRY_MAX`, default 3: extra frames issued after a WAIT ACK; legal range 0..15.
- `MISO_LAT`, default 0: cycles between presenting a frame bit on `mosi` and that bit's response being valid on `miso`; legal values 0 or 1.
- `sck` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command handshake valid.
- `cmd_ready` out 1: command handshake ready.
- `cmd_apndp` in 1: 0 selects DP, 1 selects AP.
- `cmd_rnw` in 1: 1 = read, 0 = write.
- `cmd_addr` in 2: A[3:2].
- `cmd_wdata` in 32: write data; ignored for reads.
- `rsp_valid` out 1: response handshake valid.
- `rsp_ready` in 1: response handshake ready.
- `rsp_ack` out 3: ACK as received; bit0 is the first bit on the wire.
- `rsp_rdata` out 32: read data; 0 for writes and for non-OK ACKs.
- `rsp_perr` out 1: read-data parity error; only set on an OK read.
- `rsp_retries` out 4: number of WAIT retries consumed.
- `mosi` out 1: serial frame to `swd_frontend_top.mosi`.
- `miso` in 1: from `swd_frontend_top.miso`.
- `fe_rst_n` out 1: frame window to `swd_frontend_top.rst_n`; 1 only during a frame.
- `fe_rnw` out 1: to `swd_frontend_top.rnw`.

## Operation
- Reset values: `cmd_ready`=0, `rsp_valid`=0, `rsp_ack`=0, `rsp_rdata`=0, `rsp_perr`=0, `rsp_retries`=0, `mosi`=0, `fe_rst_n`=0, `fe_rnw`=0. `cmd_ready` rises on the first edge after `rst` falls.
- States:
  - IDLE: `cmd_ready`=1.
  - GAP: `fe_rst_n`=0, `mosi`=0.
  - FRAME: `fe_rst_n`=1 for 48+`MISO_LAT` cycles.
  - RESP: `rsp_valid`=1.
- Transitions: IDLE→GAP on `cmd_valid`&`cmd_ready`; GAP→FRAME after `IDLE_CYCLES`; FRAME→GAP on retry, otherwise FRAME→RESP; RESP→IDLE on `rsp_ready`.
- The command is latched on acceptance. `fe_rnw`=`cmd_rnw` from acceptance until the response is accepted.
- Request byte: b0=1 (Start), b1=APnDP, b2=RnW, b3=A2, b4=A3, b5=^b[4:1] (even parity), b6=0 (Stop), b7=1 (Park).
  - DP write, A=0 gives 0x81.
  - DP read, A=0 gives 0xA5.
- Frame bit k on `mosi` (k = FRAME cycle index):
  - k=0..2: 0.
  - k=3..10: req[k-3].
  - k=11: 0.
  - k=12..14: 0.
  - k=15..46: wdata[k-15] for writes, 0 for reads.
  - k=47: ^wdata for writes, 0 for reads.
  - k≥48: 0.
- Write data is presented regardless of ACK; `swd_frontend_top` gates the SWDIO drive.
- `miso` is sampled at the end of FRAME cycle k+`MISO_LAT`:
  - k=12..14: ack[k-12].
  - Reads only, k=15..46: rdata[k-15].
  - Reads only, k=47: parity bit.
- Evaluation at frame end:
  - ack=3'b001 (OK): respond. For reads, `rsp_perr`=(^rdata != parity bit).
  - ack=3'b010 (WAIT) and retry count < `RETRY_MAX`: increment the retry count and go to GAP to resend the identical frame.
  - ack=3'b010 (WAIT) and retry count = `RETRY_MAX`: respond with ack 3'b010.
  - Any other ack (FAULT 3'b100, or a protocol error such as 3'b111 from no target): respond immediately, no retry.
- Response fields are stable while `rsp_valid`=1. `cmd_valid` is ignored outside IDLE.
- `rst` asserted mid-operation: on the next edge all outputs take their reset values and `fe_rst_n` drops. The in-flight command is discarded and no response is issued.

## Timing
- Command accepted at edge T0.
- GAP cycles: T0 .. T0+`IDLE_CYCLES`-1.
- Frame bit k is on `mosi` from edge T0+`IDLE_CYCLES`+k.
- `rsp_valid` rises at edge T0+`IDLE_CYCLES`+48+`MISO_LAT`, which is 52 cycles with defaults.
- Each WAIT retry adds `IDLE_CYCLES`+48+`MISO_LAT` cycles.
- Response accepted at edge T1 (`rsp_valid`&`rsp_ready`): `rsp_valid`=0 and `cmd_ready`=1 from T1. The earliest next acceptance is at T1+1.
- `fe_rst_n` is never high for more than 48+`MISO_LAT` consecutive cycles.
- `fe_rst_n` is low for at least `IDLE_CYCLES` cycles between frames.

## Test plan
- DP ABORT write (dp, write, A=0, 0x0000001E), target ACK 001:
  - `mosi` carries 000, 0x81 LSB-first, 0, 000, 0x1E LSB-first, parity 0.
  - Response: `rsp_ack`=001, `rsp_retries`=0, `rsp_valid` 52 cycles after acceptance.
- DP IDCODE read (req 0xA5), target ACK 001 with data 0x0BB11477 and parity 1: `rsp_rdata`=0x0BB11477, `rsp_perr`=0. The same transfer with parity 0 gives `rsp_perr`=1.
- WAIT handling with `RETRY_MAX`=3:
  - WAIT on every frame: 4 identical frames, each preceded by a 4-cycle `fe_rst_n` low gap; response ack 010, retries 3.
  - WAIT, WAIT, then OK: response ack 001, retries 2.
- FAULT (ack 100) on a write of 0xCAFEBABE: a single frame, no retry; response ack 100, `rsp_rdata`=0.
- `rst` pulsed at frame bit 20: on the next edge `fe_rst_n`=0, `mosi`=0, `cmd_ready`=0, and `rsp_valid` never rises. A following command completes normally.
- `rsp_ready` held low for 10 cycles: response fields hold stable, `cmd_ready` stays 0, and a concurrent `cmd_valid` is not accepted until after the response handshake.

Source files
------------

// File: rtl/swd_xfer_sequencer_if.sv
// Command/response handshake bundle between an MCU-side master and the SWD transfer sequencer.
// The master issues one command and collects exactly one response per transfer.
interface swd_xfer_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_apndp;
    logic        cmd_rnw;
    logic [1:0]  cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata;
    logic        rsp_perr;
    logic [3:0]  rsp_retries;

    modport master (
        output cmd_valid, cmd_apndp, cmd_rnw, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_perr, rsp_retries
    );

    modport slave (
        input  cmd_valid, cmd_apndp, cmd_rnw, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_perr, rsp_retries
    );
endinterface

// File: rtl/swd_xfer_sequencer.sv
// Serialises one SWD transfer per command into a fixed 48-bit frame for swd_frontend_top,
// recovers ACK/read data from miso, retries WAIT responses and returns one response per command.
module swd_xfer_sequencer #(
    parameter int IDLE_CYCLES = 4,
    parameter int RETRY_MAX   = 3,
    parameter int MISO_LAT    = 0
) (
    input  logic                  sck,
    input  logic                  rst,
    swd_xfer_sequencer_if.slave   bus,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  fe_rst_n,
    output logic                  fe_rnw
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_FRAME,
        ST_RESP
    } state_t;

    localparam logic [3:0] GAP_LAST  = 4'(IDLE_CYCLES - 1);
    localparam logic [3:0] RETRY_LIM = 4'(RETRY_MAX);
    localparam logic [5:0] LAT       = 6'(MISO_LAT);
    localparam logic [5:0] LAST_BIT  = 6'(47 + MISO_LAT);
    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;

    state_t      state_q, state_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  retry_cnt_q, retry_cnt_d;
    logic        apndp_q, apndp_d;
    logic        rnw_q, rnw_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [2:0]  rsp_ack_q, rsp_ack_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_perr_q, rsp_perr_d;
    logic [3:0]  rsp_retries_q, rsp_retries_d;
    logic        mosi_q, mosi_d;
    logic        fe_rst_n_q, fe_rst_n_d;
    logic        fe_rnw_q, fe_rnw_d;

    logic [7:0]  req_byte;
    logic [47:0] frame_vec;
    logic [5:0]  bit_nxt;
    logic [5:0]  samp_idx;
    logic        samp_valid;
    logic        ok_read;

    // Whole outgoing frame built from the latched command; retries resend it unchanged.
    always_comb begin
        req_byte  = {1'b1, 1'b0, apndp_q ^ rnw_q ^ addr_q[0] ^ addr_q[1],
                     addr_q[1], addr_q[0], rnw_q, apndp_q, 1'b1};
        frame_vec = '0;
        frame_vec[10:3] = req_byte;
        if (!rnw_q) begin
            frame_vec[46:15] = wdata_q;
            frame_vec[47]    = ^wdata_q;
        end
    end

    assign bit_nxt    = bit_cnt_q + 6'd1;
    assign samp_valid = (bit_cnt_q >= LAT);
    assign samp_idx   = bit_cnt_q - LAT;
    assign ok_read    = rnw_q && (ack_q == ACK_OK);

    always_comb begin
        state_d       = state_q;
        gap_cnt_d     = gap_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        retry_cnt_d   = retry_cnt_q;
        apndp_d       = apndp_q;
        rnw_d         = rnw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        ack_d         = ack_q;
        rdata_d       = rdata_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_ack_d     = rsp_ack_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_perr_d    = rsp_perr_q;
        rsp_retries_d = rsp_retries_q;
        fe_rnw_d      = fe_rnw_q;
        mosi_d        = 1'b0;
        fe_rst_n_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    apndp_d     = bus.cmd_apndp;
                    rnw_d       = bus.cmd_rnw;
                    addr_d      = bus.cmd_addr;
                    wdata_d     = bus.cmd_wdata;
                    fe_rnw_d    = bus.cmd_rnw;
                    cmd_ready_d = 1'b0;
                    retry_cnt_d = '0;
                    gap_cnt_d   = '0;
                    state_d     = ST_GAP;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d    = ST_FRAME;
                    bit_cnt_d  = '0;
                    fe_rst_n_d = 1'b1;
                    mosi_d     = frame_vec[0];
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            ST_FRAME: begin
                // miso lags mosi by MISO_LAT, so the sampled bit index trails bit_cnt.
                if (samp_valid && samp_idx >= 6'd12 && samp_idx <= 6'd14) begin
                    ack_d = {miso, ack_q[2:1]};
                end
                if (samp_valid && samp_idx >= 6'd15 && samp_idx <= 6'd46) begin
                    rdata_d = {miso, rdata_q[31:1]};
                end

                if (bit_cnt_q == LAST_BIT) begin
                    if (ack_q == ACK_WAIT && retry_cnt_q < RETRY_LIM) begin
                        retry_cnt_d = retry_cnt_q + 4'd1;
                        gap_cnt_d   = '0;
                        state_d     = ST_GAP;
                    end else begin
                        // The parity bit is still on miso at this edge, not yet in rdata_q.
                        rsp_valid_d   = 1'b1;
                        rsp_ack_d     = ack_q;
                        rsp_retries_d = retry_cnt_q;
                        rsp_rdata_d   = ok_read ? rdata_q : 32'd0;
                        rsp_perr_d    = ok_read && ((^rdata_q) != miso);
                        state_d       = ST_RESP;
                    end
                end else begin
                    bit_cnt_d  = bit_nxt;
                    fe_rst_n_d = 1'b1;
                    mosi_d     = (bit_nxt < 6'd48) ? frame_vec[bit_nxt] : 1'b0;
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    fe_rnw_d    = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sck) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            gap_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            retry_cnt_q   <= '0;
            apndp_q       <= 1'b0;
            rnw_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            ack_q         <= '0;
            rdata_q       <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_ack_q     <= '0;
            rsp_rdata_q   <= '0;
            rsp_perr_q    <= 1'b0;
            rsp_retries_q <= '0;
            mosi_q        <= 1'b0;
            fe_rst_n_q    <= 1'b0;
            fe_rnw_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_cnt_q     <= gap_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            retry_cnt_q   <= retry_cnt_d;
            apndp_q       <= apndp_d;
            rnw_q         <= rnw_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_ack_q     <= rsp_ack_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_perr_q    <= rsp_perr_d;
            rsp_retries_q <= rsp_retries_d;
            mosi_q        <= mosi_d;
            fe_rst_n_q    <= fe_rst_n_d;
            fe_rnw_q      <= fe_rnw_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_ack     = rsp_ack_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_perr    = rsp_perr_q;
    assign bus.rsp_retries = rsp_retries_q;
    assign mosi            = mosi_q;
    assign fe_rst_n        = fe_rst_n_q;
    assign fe_rnw          = fe_rnw_q;

endmodule

// File: tb/tb_swd_xfer_sequencer.sv
// Directed, table-driven bench for swd_xfer_sequencer with a behavioural SWD target on miso.
// Frames on mosi are captured per frame and compared against hand-computed request bytes.
module tb_swd_xfer_sequencer;

    typedef struct {
        logic        apndp;
        logic        rnw;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [11:0] acks;
        logic [31:0] rdata;
        logic        par;
        logic [7:0]  exp_req;
        logic        exp_wpar;
        logic [2:0]  exp_ack;
        logic [31:0] exp_rdata;
        logic        exp_perr;
        logic [3:0]  exp_retries;
        int          exp_frames;
        int          exp_lat;
    } vec_t;

    logic sck;
    logic rst;
    logic mosi;
    logic miso;
    logic fe_rst_n;
    logic fe_rnw;

    swd_xfer_sequencer_if bus_if ();

    swd_xfer_sequencer dut (
        .sck      (sck),
        .rst      (rst),
        .bus      (bus_if),
        .mosi     (mosi),
        .miso     (miso),
        .fe_rst_n (fe_rst_n),
        .fe_rnw   (fe_rnw)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Target context, written by the main sequence and read by the target process.
    logic [11:0] ctx_acks  = '0;
    logic        ctx_rnw   = 1'b0;
    logic [31:0] ctx_rdata = '0;
    logic        ctx_par   = 1'b0;
    int          frame_base = 0;

    // Frame records, written only by the target process.
    logic [47:0] frames     [64];
    int          frame_lens [64];
    int          gap_before [64];
    int          total_frames = 0;

    vec_t vecs [8];

    initial begin
        sck = 1'b0;
        forever #5 sck = ~sck;
    end

    // Target model: mid-cycle it captures mosi and drives the response bit for the current frame index.
    initial begin
        int  idx;
        int  k;
        int  ai;
        int  gap_run;
        logic in_frame;
        logic [2:0] ack;
        idx      = 0;
        gap_run  = 0;
        in_frame = 1'b0;
        miso     = 1'b0;
        forever begin
            @(negedge sck);
            if (fe_rst_n) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    idx = total_frames;
                    if (total_frames < 63) total_frames = total_frames + 1;
                    frames[idx]     = '0;
                    frame_lens[idx] = 0;
                    gap_before[idx] = gap_run;
                    gap_run = 0;
                end
                k  = frame_lens[idx];
                ai = idx - frame_base;
                if (ai > 3) ai = 3;
                if (ai < 0) ai = 0;
                ack = ctx_acks[3*ai +: 3];
                if (k < 48) frames[idx][k] = mosi;
                if (k >= 12 && k <= 14)
                    miso = ack[k-12];
                else if (k >= 15 && k <= 46)
                    miso = (ctx_rnw && ack == 3'b001) ? ctx_rdata[k-15] : 1'b1;
                else if (k == 47)
                    miso = (ctx_rnw && ack == 3'b001) ? ctx_par : 1'b1;
                else
                    miso = 1'b0;
                frame_lens[idx] = k + 1;
            end else begin
                in_frame = 1'b0;
                miso     = 1'b0;
                gap_run  = gap_run + 1;
            end
        end
    end

    function automatic vec_t mk_vec(
        input logic apndp, input logic rnw, input logic [1:0] addr, input logic [31:0] wdata,
        input logic [11:0] acks, input logic [31:0] rdata, input logic par,
        input logic [7:0] exp_req, input logic exp_wpar, input logic [2:0] exp_ack,
        input logic [31:0] exp_rdata, input logic exp_perr, input logic [3:0] exp_retries,
        input int exp_frames, input int exp_lat);
        vec_t v;
        v.apndp = apndp;  v.rnw = rnw;  v.addr = addr;  v.wdata = wdata;
        v.acks = acks;    v.rdata = rdata;  v.par = par;
        v.exp_req = exp_req;  v.exp_wpar = exp_wpar;  v.exp_ack = exp_ack;
        v.exp_rdata = exp_rdata;  v.exp_perr = exp_perr;  v.exp_retries = exp_retries;
        v.exp_frames = exp_frames;  v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for cmd_ready, loads the target context and completes the command handshake.
    task automatic send_cmd(input vec_t v);
        int waited;
        waited = 0;
        @(negedge sck);
        while (!bus_if.cmd_ready && waited < 40) begin
            @(negedge sck);
            waited = waited + 1;
        end
        check_output("cmd_ready_wait", 64'(waited < 40), 64'd1);
        ctx_acks   = v.acks;
        ctx_rnw    = v.rnw;
        ctx_rdata  = v.rdata;
        ctx_par    = v.par;
        frame_base = total_frames;
        bus_if.cmd_apndp = v.apndp;
        bus_if.cmd_rnw   = v.rnw;
        bus_if.cmd_addr  = v.addr;
        bus_if.cmd_wdata = v.wdata;
        bus_if.cmd_valid = 1'b1;
        @(posedge sck);
        #1;
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int n = 1; n <= 600; n++) begin
            @(posedge sck);
            #1;
            if (bus_if.rsp_valid) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) check_output("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_frames(input vec_t v);
        logic [47:0] ef;
        int cnt;
        ef = '0;
        ef[10:3] = v.exp_req;
        if (!v.rnw) ef[46:15] = v.wdata;
        ef[47] = v.exp_wpar;
        cnt = total_frames - frame_base;
        check_output("frame_count", 64'(cnt), 64'(v.exp_frames));
        if (cnt > 4) cnt = 4;
        for (int i = 0; i < cnt; i++) begin
            check_output("frame_bits", 64'(frames[frame_base+i]), 64'(ef));
            check_output("frame_len", 64'(frame_lens[frame_base+i]), 64'd48);
            if (i > 0) check_output("retry_gap", 64'(gap_before[frame_base+i]), 64'd4);
        end
    endtask

    task automatic accept_rsp();
        bus_if.rsp_ready = 1'b1;
        @(posedge sck);
        #1;
        bus_if.rsp_ready = 1'b0;
        check_output("rsp_valid_after_hs", 64'(bus_if.rsp_valid), 64'd0);
        check_output("cmd_ready_after_hs", 64'(bus_if.cmd_ready), 64'd1);
    endtask

    task automatic apply_stimulus(input vec_t v);
        int lat;
        send_cmd(v);
        wait_rsp(lat);
        check_output("latency", 64'(lat), 64'(v.exp_lat));
        check_output("rsp_ack", 64'(bus_if.rsp_ack), 64'(v.exp_ack));
        check_output("rsp_rdata", 64'(bus_if.rsp_rdata), 64'(v.exp_rdata));
        check_output("rsp_perr", 64'(bus_if.rsp_perr), 64'(v.exp_perr));
        check_output("rsp_retries", 64'(bus_if.rsp_retries), 64'(v.exp_retries));
        check_output("fe_rnw", 64'(fe_rnw), 64'(v.rnw));
        check_output("cmd_ready_in_resp", 64'(bus_if.cmd_ready), 64'd0);
        check_frames(v);
        accept_rsp();
    endtask

    initial begin
        int lat;
        int rises;
        vec_t sv;

        vecs[0] = mk_vec(1'b0, 1'b0, 2'b00, 32'h0000001E, {4{3'b001}}, 32'h0, 1'b0,
                         8'h81, 1'b0, 3'b001, 32'h0, 1'b0, 4'd0, 1, 52);
        vecs[1] = mk_vec(1'b0, 1'b1, 2'b00, 32'h0, {4{3'b001}}, 32'h0BB11477, 1'b1,
                         8'hA5, 1'b0, 3'b001, 32'h0BB11477, 1'b0, 4'd0, 1, 52);
        vecs[2] = mk_vec(1'b0, 1'b1, 2'b00, 32'h0, {4{3'b001}}, 32'h0BB11477, 1'b0,
                         8'hA5, 1'b0, 3'b001, 32'h0BB11477, 1'b1, 4'd0, 1, 52);
        vecs[3] = mk_vec(1'b1, 1'b1, 2'b01, 32'h0, {4{3'b010}}, 32'h12345678, 1'b0,
                         8'hAF, 1'b0, 3'b010, 32'h0, 1'b0, 4'd3, 4, 208);
        vecs[4] = mk_vec(1'b1, 1'b0, 2'b11, 32'hA5A5A5A4, {3'b001, 3'b001, 3'b010, 3'b010}, 32'h0, 1'b0,
                         8'hBB, 1'b1, 3'b001, 32'h0, 1'b0, 4'd2, 3, 156);
        vecs[5] = mk_vec(1'b0, 1'b0, 2'b10, 32'hCAFEBABE, {4{3'b100}}, 32'h0, 1'b0,
                         8'hB1, 1'b0, 3'b100, 32'h0, 1'b0, 4'd0, 1, 52);
        vecs[6] = mk_vec(1'b0, 1'b1, 2'b01, 32'h0, {4{3'b111}}, 32'h0, 1'b0,
                         8'h8D, 1'b0, 3'b111, 32'h0, 1'b0, 4'd0, 1, 52);
        vecs[7] = mk_vec(1'b0, 1'b1, 2'b11, 32'h0, {3'b001, 3'b001, 3'b001, 3'b010}, 32'hDEADBEEF, 1'b0,
                         8'hBD, 1'b0, 3'b001, 32'hDEADBEEF, 1'b0, 4'd1, 2, 104);

        rst = 1'b1;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_apndp = 1'b0;
        bus_if.cmd_rnw   = 1'b0;
        bus_if.cmd_addr  = 2'b00;
        bus_if.cmd_wdata = 32'h0;
        bus_if.rsp_ready = 1'b0;

        repeat (3) @(posedge sck);
        #1;
        check_output("reset_cmd_ready", 64'(bus_if.cmd_ready), 64'd0);
        check_output("reset_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
        check_output("reset_rsp_ack", 64'(bus_if.rsp_ack), 64'd0);
        check_output("reset_rsp_rdata", 64'(bus_if.rsp_rdata), 64'd0);
        check_output("reset_rsp_perr", 64'(bus_if.rsp_perr), 64'd0);
        check_output("reset_rsp_retries", 64'(bus_if.rsp_retries), 64'd0);
        check_output("reset_mosi", 64'(mosi), 64'd0);
        check_output("reset_fe_rst_n", 64'(fe_rst_n), 64'd0);
        check_output("reset_fe_rnw", 64'(fe_rnw), 64'd0);
        rst = 1'b0;
        @(posedge sck);
        #1;
        check_output("cmd_ready_after_reset", 64'(bus_if.cmd_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            $display("[TB] vector %0d", i);
            apply_stimulus(vecs[i]);
        end

        // Reset while frame bit 20 is on the wire, then a normal transfer.
        $display("[TB] reset mid-frame");
        send_cmd(vecs[0]);
        repeat (24) @(posedge sck);
        #1;
        check_output("fe_rst_n_at_bit20", 64'(fe_rst_n), 64'd1);
        rst = 1'b1;
        @(posedge sck);
        #1;
        rst = 1'b0;
        check_output("abort_fe_rst_n", 64'(fe_rst_n), 64'd0);
        check_output("abort_mosi", 64'(mosi), 64'd0);
        check_output("abort_cmd_ready", 64'(bus_if.cmd_ready), 64'd0);
        check_output("abort_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
        rises = 0;
        for (int n = 0; n < 80; n++) begin
            @(posedge sck);
            #1;
            if (bus_if.rsp_valid) rises = rises + 1;
        end
        check_output("abort_no_response", 64'(rises), 64'd0);
        apply_stimulus(vecs[0]);

        // Back-pressured response with a concurrent command held on the bus.
        $display("[TB] response stall");
        send_cmd(vecs[1]);
        wait_rsp(lat);
        check_output("stall_latency", 64'(lat), 64'd52);
        sv = vecs[0];
        bus_if.cmd_apndp = sv.apndp;
        bus_if.cmd_rnw   = sv.rnw;
        bus_if.cmd_addr  = sv.addr;
        bus_if.cmd_wdata = sv.wdata;
        bus_if.cmd_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(posedge sck);
            #1;
            check_output("stall_rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
            check_output("stall_rsp_ack", 64'(bus_if.rsp_ack), 64'd1);
            check_output("stall_rsp_rdata", 64'(bus_if.rsp_rdata), 64'h0BB11477);
            check_output("stall_cmd_ready", 64'(bus_if.cmd_ready), 64'd0);
        end
        ctx_acks   = sv.acks;
        ctx_rnw    = sv.rnw;
        ctx_rdata  = sv.rdata;
        ctx_par    = sv.par;
        frame_base = total_frames;
        accept_rsp();
        @(posedge sck);
        #1;
        bus_if.cmd_valid = 1'b0;
        check_output("stall_next_accepted", 64'(bus_if.cmd_ready), 64'd0);
        wait_rsp(lat);
        check_output("stall_next_latency", 64'(lat), 64'd52);
        check_output("stall_next_ack", 64'(bus_if.rsp_ack), 64'd1);
        check_frames(sv);
        accept_rsp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got expired, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
